// File: rtl/strassen_result_drain.sv
// Result-matrix drain: streams the product buffer row-major over valid/ready
// with row/matrix markers and a running checksum.
module strassen_result_drain #(
  parameter int MAT_SIZE      = 256,
  parameter int ELEM_BITWIDTH = 8,
  parameter int ACC_BITWIDTH  = 2*ELEM_BITWIDTH+$clog2(MAT_SIZE),
  parameter int ADDR_W        = 2*$clog2(MAT_SIZE)
) (
  input  logic                    fast_clk,
  input  logic                    rst,
  input  logic                    done_final,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [ACC_BITWIDTH-1:0] rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_BITWIDTH-1:0] out_data,
  output logic                    out_row_last,
  output logic                    out_last,
  output logic                    busy,
  output logic                    drain_done,
  output logic [31:0]             checksum,
  output logic                    restart_err
);

  localparam int LG = $clog2(MAT_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  typedef struct packed {
    logic [ACC_BITWIDTH-1:0] data;
    logic                    row_last;
    logic                    last;
  } ent_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              pend_q;
  logic              pend_row_last_q;
  logic              pend_last_q;
  ent_t              fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        credit;
  ent_t              head;
  logic              pop;
  logic              issue;
  logic              start;
  logic              col_end;
  logic              mat_end;

  assign head      = fifo_q[rd_ptr_q];
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign col_end   = (addr_q[LG-1:0] == {LG{1'b1}});
  assign mat_end   = (addr_q == {ADDR_W{1'b1}});

  // In-flight read plus buffered entries, minus the slot freed this cycle.
  assign credit = {1'b0, pend_q} + cnt_q - {1'b0, pop};
  assign issue  = (state == DRAIN) && (credit < 2'd2);

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (done_final) begin
          state_nx = DRAIN;
          start    = 1'b1;
        end
      end
      DRAIN: if (issue && mat_end) state_nx = FLUSH;
      FLUSH: if (pop && head.last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state           <= IDLE;
      addr_q          <= '0;
      pend_q          <= 1'b0;
      pend_row_last_q <= 1'b0;
      pend_last_q     <= 1'b0;
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      cnt_q           <= 2'd0;
      checksum        <= 32'd0;
      restart_err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (start)      addr_q <= '0;
      else if (issue) addr_q <= addr_q + 1'b1;
      pend_q          <= issue;
      pend_row_last_q <= issue & col_end;
      pend_last_q     <= issue & mat_end;
      if (pend_q) begin
        fifo_q[wr_ptr_q] <= ent_t'{
          data:     rd_data,
          row_last: pend_row_last_q,
          last:     pend_last_q
        };
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
      if (start)    checksum <= 32'd0;
      else if (pop) checksum <= checksum + 32'(head.data);
      if (done_final && (state != IDLE)) restart_err <= 1'b1;
    end
  end

  assign rd_en        = issue;
  assign rd_addr      = addr_q;
  assign out_data     = head.data;
  assign out_row_last = head.row_last;
  assign out_last     = head.last;
  assign busy         = (state != IDLE);
  assign drain_done   = (state == DONE);

endmodule

// File: tb/tb_strassen_result_drain.sv
// Directed bench: 4x4 drain scenarios plus a full 256x256 checksum wrap run.
module tb_strassen_result_drain;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          done_final;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_row_last;
  logic          out_last;
  logic          busy;
  logic          drain_done;
  logic [31:0]   checksum;
  logic          restart_err;

  logic          b_done_final;
  logic          b_rd_en;
  logic [15:0]   b_rd_addr;
  logic [23:0]   b_rd_data;
  logic          b_valid;
  logic          b_ready;
  logic [23:0]   b_data;
  logic          b_row_last;
  logic          b_last;
  logic          b_busy;
  logic          b_drain_done;
  logic [31:0]   b_checksum;
  logic          b_restart_err;

  always #5 clk = ~clk;

  strassen_result_drain #(.MAT_SIZE(N)) dut (
    .fast_clk(clk), .rst(rst), .done_final(done_final),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_last(out_last), .busy(busy),
    .drain_done(drain_done), .checksum(checksum),
    .restart_err(restart_err)
  );

  strassen_result_drain #(.MAT_SIZE(256)) dut_big (
    .fast_clk(clk), .rst(rst), .done_final(b_done_final),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .out_row_last(b_row_last), .out_last(b_last), .busy(b_busy),
    .drain_done(b_drain_done), .checksum(b_checksum),
    .restart_err(b_restart_err)
  );

  // Buffer models: element i holds i; off-cycle data is junk.
  always @(posedge clk) begin
    rd_data   <= rd_en ? DW'(rd_addr) : 18'h2abcd;
    b_rd_data <= b_rd_en ? 24'hffffff : 24'h000000;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  int          t0;
  int          beat_cnt;
  int          issued;
  int          done_cnt;
  int          first_v_off;
  int          done_off;
  bit          prev_stall;
  logic [DW-1:0] prev_data;
  int          b_beats = 0;
  int          b_done_cnt = 0;

  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_data));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && first_v_off < 0) first_v_off = cyc - t0;
    if (out_valid && out_ready) begin
      check("beat_data", 32'(out_data), 32'(beat_cnt));
      check("beat_row_last", 32'(out_row_last),
            32'(beat_cnt % N == N - 1));
      check("beat_last", 32'(out_last), 32'(beat_cnt == N*N - 1));
      beat_cnt++;
    end
    if (rd_en) begin
      issued++;
      check("inflight", 32'(issued - beat_cnt <= 2), 32'd1);
    end
    if (drain_done) begin
      done_cnt++;
      done_off = cyc - t0;
    end
    if (b_valid && b_ready) b_beats++;
    if (b_drain_done) b_done_cnt++;
  end

  task automatic mon_clear();
    beat_cnt    = 0;
    issued      = 0;
    done_cnt    = 0;
    first_v_off = -1;
    done_off    = -1;
    prev_stall  = 1'b0;
  endtask

  function automatic logic rdy(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_cycle(input int mode);
    @(posedge clk);
    #1;
    done_final = 1'b0;
    out_ready  = rdy(mode);
  endtask

  task automatic start(input int mode);
    mon_clear();
    @(posedge clk);
    #1;
    t0         = cyc;
    done_final = 1'b1;
    out_ready  = rdy(mode);
  endtask

  task automatic run_until_done(input int mode, input int bound,
                                input int pulse_at);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      drive_cycle(mode);
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
      if (i == pulse_at) done_final = 1'b1;
    end
    check("drain_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int mode;
    int beats;
    int sum;
    int first_v;
    int done_lat;
  } vec_t;

  vec_t vecs [2];

  initial begin
    vecs[0] = '{mode: 0, beats: 16, sum: 120, first_v: 3, done_lat: 19};
    vecs[1] = '{mode: 1, beats: 16, sum: 120, first_v: 3, done_lat: -1};

    rst          = 1'b1;
    done_final   = 1'b0;
    out_ready    = 1'b0;
    b_done_final = 1'b0;
    b_ready      = 1'b1;
    mon_clear();
    t0 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_row_last", 32'(out_row_last), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(drain_done), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_err", 32'(restart_err), 32'd0);

    foreach (vecs[k]) begin
      start(vecs[k].mode);
      run_until_done(vecs[k].mode, 100, -1);
      check("vec_beats", 32'(beat_cnt), 32'(vecs[k].beats));
      check("vec_checksum", checksum, 32'(vecs[k].sum));
      check("vec_first_valid", 32'(first_v_off), 32'(vecs[k].first_v));
      if (vecs[k].done_lat >= 0)
        check("vec_done_cycle", 32'(done_off), 32'(vecs[k].done_lat));
      @(negedge clk);
      check("vec_busy_low", 32'(busy), 32'd0);
      check("vec_err", 32'(restart_err), 32'd0);
    end

    start(2);
    repeat (20) drive_cycle(2);
    @(negedge clk);
    check("stall_issued", 32'(issued), 32'd2);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_data", 32'(out_data), 32'd0);
    check("stall_beats", 32'(beat_cnt), 32'd0);
    run_until_done(0, 100, -1);
    check("stall_total", 32'(beat_cnt), 32'd16);
    check("stall_checksum", checksum, 32'd120);

    start(0);
    for (int i = 0; i < 40; i++) begin
      if (beat_cnt >= 5) break;
      drive_cycle(0);
    end
    check("rst_mid_reached", 32'(beat_cnt >= 5), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstm_valid", 32'(out_valid), 32'd0);
    check("rstm_rd_en", 32'(rd_en), 32'd0);
    check("rstm_rd_addr", 32'(rd_addr), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_checksum", checksum, 32'd0);
    check("rstm_data", 32'(out_data), 32'd0);
    check("rstm_flags", 32'({out_row_last, out_last}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstm_late_read", 32'(out_valid), 32'd0);
    start(0);
    run_until_done(0, 100, -1);
    check("rstm_beats", 32'(beat_cnt), 32'd16);
    check("rstm_checksum2", checksum, 32'd120);
    check("rstm_first", 32'(first_v_off), 32'd3);

    do_rst();
    start(0);
    run_until_done(0, 100, 5);
    check("mid_restart_err", 32'(restart_err), 32'd1);
    check("mid_restart_beats", 32'(beat_cnt), 32'd16);
    check("mid_restart_sum", checksum, 32'd120);
    check("mid_restart_done", 32'(done_off), 32'd19);

    do_rst();
    @(negedge clk);
    check("err_cleared", 32'(restart_err), 32'd0);
    start(0);
    run_until_done(0, 100, 18);
    check("done_hit_cycle", 32'(done_off), 32'd19);
    check("done_hit_err", 32'(restart_err), 32'd1);
    @(negedge clk);
    check("done_hit_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("done_hit_idle", 32'({busy, rd_en}), 32'd0);
    check("done_hit_sum", checksum, 32'd120);

    @(posedge clk);
    #1 b_done_final = 1'b1;
    @(posedge clk);
    #1 b_done_final = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (b_done_cnt != 0) break;
      @(posedge clk);
    end
    check("big_done", 32'(b_done_cnt), 32'd1);
    check("big_beats", 32'(b_beats), 32'd65536);
    check("big_checksum", b_checksum, 32'hffff0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
